mem_port_arbiter: RTL and testbench

- Sequences and shares one single-port, fixed-latency memory between two requesters of the pipelined core: instruction fetch (F stage) and data load/store (M stage).
- Captures each request, issues it to memory, counts the memory latency, and returns registered read data with a one-cycle acknowledge.
- Generates stall signals for the core's stall/flush logic while a requester waits.
- Replaces split instruction/data memories when the core is built against a unified memory.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_latency_ctr.sv | 21 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and counter-width helper for the unified-memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arbState_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int MIN_CTR_W = 1;

  // Bits needed to hold 0..maxVal.
  function automatic int ctrW(input int maxVal);
    return (maxVal < 1) ? MIN_CTR_W : $clog2(maxVal + 1);
  endfunction
endpackage

// File: rtl/mem_arb_latency_ctr.sv
// Memory latency down-counter: load on issue, count down while waiting, flag zero.
module mem_arb_latency_ctr #(
  parameter int W = 2
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= loadVal;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports
// of the core; data wins by default, fetch wins once data has starved it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
)(
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_IReq,
  input  logic [ADDR_W-1:0] i_IAddr,
  input  logic              i_IKill,
  output logic [DATA_W-1:0] o_IRData,
  output logic              o_IAck,
  output logic              o_StallF,
  input  logic              i_DReq,
  input  logic              i_DWe,
  input  logic [ADDR_W-1:0] i_DAddr,
  input  logic [DATA_W-1:0] i_DWData,
  output logic [DATA_W-1:0] o_DRData,
  output logic              o_DAck,
  output logic              o_StallM,
  output logic              o_MemEn,
  output logic              o_MemWe,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic [DATA_W-1:0] o_MemWData,
  input  logic [DATA_W-1:0] i_MemRData
);
  localparam int LAT_W = ctrW(MEM_LAT);
  localparam int STV_W = ctrW(STARVE_MAX);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  arbState_t        state, nextState;
  owner_t           owner;
  logic             isWrite, killFlag, latZero;
  logic             anyReq, grantI, fetchLive, fetchDropped;
  logic [STV_W-1:0] starveCnt;

  assign anyReq       = i_IReq | i_DReq;
  assign grantI       = i_IReq & (~i_DReq | (starveCnt == STV_LIMIT));
  assign fetchLive    = (owner == OWN_I) & ((state == ISSUE) | (state == WAIT));
  assign fetchDropped = killFlag | i_IKill;

  assign o_StallF = ~i_Reset & i_IReq & ~o_IAck;
  assign o_StallM = ~i_Reset & i_DReq & ~o_DAck;

  mem_arb_latency_ctr #(.W(LAT_W)) uLatCtr (
    .clk     (i_Clk),
    .rst     (i_Reset),
    .load    (state == ISSUE),
    .loadVal (LAT_LOAD),
    .dec     (state == WAIT),
    .zero    (latZero)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (latZero) nextState = ACK;
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_IRData   <= '0;
      o_DRData   <= '0;
      o_IAck     <= 1'b0;
      o_DAck     <= 1'b0;
      o_MemEn    <= 1'b0;
      o_MemWe    <= 1'b0;
      o_MemAddr  <= '0;
      o_MemWData <= '0;
      owner      <= OWN_I;
      isWrite    <= 1'b0;
      killFlag   <= 1'b0;
      starveCnt  <= '0;
    end else begin
      o_MemEn <= 1'b0;
      o_MemWe <= 1'b0;
      o_IAck  <= 1'b0;
      o_DAck  <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_IReq || grantI)          starveCnt <= '0;
          else if (starveCnt != STV_LIMIT) starveCnt <= starveCnt + 1'b1;
          if (anyReq) begin
            owner      <= grantI ? OWN_I : OWN_D;
            isWrite    <= ~grantI & i_DWe;
            o_MemEn    <= 1'b1;
            o_MemWe    <= ~grantI & i_DWe;
            o_MemAddr  <= grantI ? i_IAddr : i_DAddr;
            o_MemWData <= grantI ? '0 : i_DWData;
            killFlag   <= 1'b0;
          end
        end
        ISSUE: if (fetchLive && i_IKill) killFlag <= 1'b1;
        WAIT: begin
          if (fetchLive && i_IKill) killFlag <= 1'b1;
          // Ack and read data register together so both are visible in the ACK cycle.
          if (latZero) begin
            if (owner == OWN_I) begin
              if (!fetchDropped) begin
                o_IAck   <= 1'b1;
                o_IRData <= i_MemRData;
              end
            end else begin
              o_DAck <= 1'b1;
              if (!isWrite) o_DRData <= i_MemRData;
            end
          end
        end
        ACK:     killFlag <= 1'b0;
        default: killFlag <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        iReq = 0, iKill = 0, dReq = 0, dWe = 0;
  logic [31:0] iAddr = 0, dAddr = 0, dWData = 0;
  logic [31:0] iRData, dRData, memAddr, memWData, memRData;
  logic        iAck, dAck, stallF, stallM, memEn, memWe;

  logic        d1Req = 0;
  logic [31:0] d1Addr = 0;
  logic [31:0] iRData1, dRData1, memAddr1, memWData1, memRData1;
  logic        iAck1, dAck1, stallF1, stallM1, memEn1, memWe1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut0 (
    .i_Clk(clk), .i_Reset(rst),
    .i_IReq(iReq), .i_IAddr(iAddr), .i_IKill(iKill),
    .o_IRData(iRData), .o_IAck(iAck), .o_StallF(stallF),
    .i_DReq(dReq), .i_DWe(dWe), .i_DAddr(dAddr), .i_DWData(dWData),
    .o_DRData(dRData), .o_DAck(dAck), .o_StallM(stallM),
    .o_MemEn(memEn), .o_MemWe(memWe), .o_MemAddr(memAddr), .o_MemWData(memWData),
    .i_MemRData(memRData)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .i_Clk(clk), .i_Reset(rst),
    .i_IReq(1'b0), .i_IAddr(32'h0), .i_IKill(1'b0),
    .o_IRData(iRData1), .o_IAck(iAck1), .o_StallF(stallF1),
    .i_DReq(d1Req), .i_DWe(1'b0), .i_DAddr(d1Addr), .i_DWData(32'h0),
    .o_DRData(dRData1), .o_DAck(dAck1), .o_StallM(stallM1),
    .o_MemEn(memEn1), .o_MemWe(memWe1), .o_MemAddr(memAddr1), .o_MemWData(memWData1),
    .i_MemRData(memRData1)
  );

  // Memory models: read data valid exactly MEM_LAT cycles after the strobe, junk otherwise.
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic [31:0] p0a, p0b, p1a;
  always @(posedge clk) begin
    if (rst) begin
      mem0[8'h40] <= 32'hDEADBEEF;
      mem0[8'hC0] <= 32'hCAFEF00D;
      mem1[8'h10] <= 32'h00001234;
    end else if (memEn && memWe) mem0[memAddr[9:2]] <= memWData;
    p0a <= memEn ? mem0[memAddr[9:2]] : 32'hBADBAD00;
    p0b <= p0a;
    p1a <= memEn1 ? mem1[memAddr1[9:2]] : 32'hBADBAD01;
  end
  assign memRData  = p0b;
  assign memRData1 = p1a;

  int cyc = 0, base = 0, total = 0, bad = 0, stallFCnt = 0, stallFBase = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {int c; logic [31:0] a; logic we; logic [31:0] d;} ev_t;
  ev_t issQ[$], iAckQ[$], dAckQ[$], iss1Q[$], dAck1Q[$];

  logic pI = 0, pAck = 0, pK = 0, pR = 1, pD = 0, pDAck = 0;
  always @(negedge clk) begin
    if (memEn)  issQ.push_back('{cyc - base, memAddr, memWe, memWData});
    if (iAck)   iAckQ.push_back('{cyc - base, 32'h0, 1'b0, iRData});
    if (dAck)   dAckQ.push_back('{cyc - base, 32'h0, 1'b0, dRData});
    if (memEn1) iss1Q.push_back('{cyc - base, memAddr1, memWe1, memWData1});
    if (dAck1)  dAck1Q.push_back('{cyc - base, 32'h0, 1'b0, dRData1});
    if (stallF) stallFCnt <= stallFCnt + 1;
    // Requests may only drop after their ack, a kill, or a reset.
    if (pI && !pAck && !pK && !pR && !rst) chk("iWithdraw", 32'(iReq), 32'd1);
    if (pD && !pDAck && !pR && !rst)       chk("dWithdraw", 32'(dReq), 32'd1);
    pI <= iReq; pAck <= iAck; pK <= iKill; pR <= rst; pD <= dReq; pDAck <= dAck;
  end

  function automatic int qSize(input int sel);
    case (sel)
      0: return issQ.size();
      1: return iAckQ.size();
      2: return dAckQ.size();
      3: return iss1Q.size();
      default: return dAck1Q.size();
    endcase
  endfunction

  function automatic ev_t qGet(input int sel, input int k);
    case (sel)
      0: return issQ[k];
      1: return iAckQ[k];
      2: return dAckQ[k];
      3: return iss1Q[k];
      default: return dAck1Q[k];
    endcase
  endfunction

  // sel 0/3: issue logs (addr, we, wdata on stores); 1/2/4: ack logs (data).
  task automatic chkEv(input string tag, input int sel, input int k, input int c,
                       input logic [31:0] a, input logic we, input logic [31:0] d);
    ev_t e;
    if (qSize(sel) <= k) chk({tag, "_missing"}, qSize(sel), k + 1);
    else begin
      e = qGet(sel, k);
      chk({tag, "_cyc"}, e.c, c);
      if (sel == 0 || sel == 3) begin
        chk({tag, "_addr"}, e.a, a);
        chk({tag, "_we"}, 32'(e.we), 32'(we));
        if (we) chk({tag, "_wdata"}, e.d, d);
      end else chk({tag, "_data"}, e.d, d);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Marks the current cycle as cycle 1 of a scenario and clears the logs.
  task automatic start();
    step();
    base = cyc - 1;
    stallFBase = stallFCnt;
    issQ.delete(); iAckQ.delete(); dAckQ.delete(); iss1Q.delete(); dAck1Q.delete();
  endtask

  // Holds each request until it has collected its acks, then drops it.
  task automatic serve(input int nD, input int nI, input int maxc);
    int n = 0;
    while (nD > 0 || nI > 0) begin
      @(negedge clk);
      if (dAck) nD--;
      if (iAck) nI--;
      n++;
      if (n > maxc) begin
        chk("serveTimeout", n, maxc);
        break;
      end
      step();
      dReq = (nD > 0);
      iReq = (nI > 0);
    end
  endtask

  initial begin
    // Reset, with both requests high: stalls must stay forced low.
    iReq = 1; dReq = 1;
    step(); step();
    @(negedge clk);
    chk("rst_stallF", 32'(stallF), 0);
    chk("rst_stallM", 32'(stallM), 0);
    chk("rst_memEn", 32'(memEn), 0);
    chk("rst_memWe", 32'(memWe), 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWData", memWData, 0);
    chk("rst_iAck", 32'(iAck), 0);
    chk("rst_dAck", 32'(dAck), 0);
    chk("rst_iRData", iRData, 0);
    chk("rst_dRData", dRData, 0);
    chk("rst_memEn1", 32'(memEn1), 0);
    step(); rst = 0; iReq = 0; dReq = 0;
    step();

    // Single fetch.
    start(); iAddr = 32'h100; iReq = 1;
    serve(0, 1, 20);
    @(negedge clk);
    chk("f_ackLow", 32'(iAck), 0);
    chk("f_rdHeld", iRData, 32'hDEADBEEF);
    chk("f_stallCnt", stallFCnt - stallFBase, 4);
    chk("f_nIss", qSize(0), 1);
    chkEv("f_iss", 0, 0, 2, 32'h100, 1'b0, 0);
    chk("f_nIAck", qSize(1), 1);
    chkEv("f_iAck", 1, 0, 5, 0, 1'b0, 32'hDEADBEEF);
    chk("f_nDAck", qSize(2), 0);

    // Collision: store wins, fetch follows.
    start(); iAddr = 32'h100; iReq = 1;
    dReq = 1; dWe = 1; dAddr = 32'h200; dWData = 32'h55;
    serve(1, 1, 30);
    dWe = 0;
    chk("c_nIss", qSize(0), 2);
    chkEv("c_iss0", 0, 0, 2, 32'h200, 1'b1, 32'h55);
    chkEv("c_iss1", 0, 1, 7, 32'h100, 1'b0, 0);
    chkEv("c_dAck", 2, 0, 5, 0, 1'b0, 32'h0);
    chkEv("c_iAck", 1, 0, 10, 0, 1'b0, 32'hDEADBEEF);

    // Starvation: four data grants, then the fetch, then data again.
    start(); dAddr = 32'h200; dReq = 1; iAddr = 32'h100; iReq = 1;
    serve(6, 1, 60);
    chk("s_nIss", qSize(0), 7);
    for (int k = 0; k < 7; k++)
      chkEv($sformatf("s_iss%0d", k), 0, k, 2 + 5 * k, (k == 4) ? 32'h100 : 32'h200, 1'b0, 0);
    chk("s_nDAck", qSize(2), 6);
    chkEv("s_dAck0", 2, 0, 5, 0, 1'b0, 32'h55);
    chkEv("s_dAck5", 2, 5, 35, 0, 1'b0, 32'h55);
    chkEv("s_iAck", 1, 0, 25, 0, 1'b0, 32'hDEADBEEF);

    // Fetch kill with redirect.
    start(); iAddr = 32'h100; iReq = 1;
    step();
    step(); iKill = 1; iAddr = 32'h300;
    step(); iKill = 0;
    step();
    @(negedge clk);
    chk("k_noAck", 32'(iAck), 0);
    chk("k_rdKept", iRData, 32'hDEADBEEF);
    serve(0, 1, 20);
    chk("k_nIss", qSize(0), 2);
    chkEv("k_iss0", 0, 0, 2, 32'h100, 1'b0, 0);
    chkEv("k_iss1", 0, 1, 7, 32'h300, 1'b0, 0);
    chk("k_nIAck", qSize(1), 1);
    chkEv("k_iAck", 1, 0, 10, 0, 1'b0, 32'hCAFEF00D);

    // Kill during a load is ignored; address change after grant has no effect.
    start(); dWe = 0; dAddr = 32'h200; dReq = 1;
    step();
    step(); iKill = 1; dAddr = 32'h300;
    step(); iKill = 0;
    serve(1, 0, 20);
    chk("kd_nDAck", qSize(2), 1);
    chkEv("kd_dAck", 2, 0, 5, 0, 1'b0, 32'h55);
    chk("kd_nIAck", qSize(1), 0);

    // Reset in the middle of WAIT drops the load.
    start(); dAddr = 32'h200; dReq = 1;
    step();
    step(); rst = 1;
    @(negedge clk);
    chk("r_stallMForced", 32'(stallM), 0);
    step(); rst = 0; dReq = 0;
    @(negedge clk);
    chk("r_memEn", 32'(memEn), 0);
    chk("r_memWe", 32'(memWe), 0);
    chk("r_memAddr", memAddr, 0);
    chk("r_dAck", 32'(dAck), 0);
    chk("r_dRData", dRData, 0);
    chk("r_iRData", iRData, 0);
    repeat (6) step();
    chk("r_nDAck", qSize(2), 0);
    chk("r_nIss", qSize(0), 1);

    // MEM_LAT=1 instance: two back-to-back loads.
    start(); d1Addr = 32'h40; d1Req = 1;
    begin
      int acks = 0;
      for (int n = 0; n < 15 && acks < 2; n++) begin
        @(negedge clk);
        if (dAck1) acks++;
        step();
        if (acks == 2) d1Req = 0;
      end
      chk("l1_acks", acks, 2);
    end
    chk("l1_nIss", qSize(3), 2);
    chkEv("l1_iss0", 3, 0, 2, 32'h40, 1'b0, 0);
    chkEv("l1_iss1", 3, 1, 6, 32'h40, 1'b0, 0);
    chkEv("l1_dAck0", 4, 0, 4, 0, 1'b0, 32'h1234);
    chkEv("l1_dAck1", 4, 1, 8, 0, 1'b0, 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
